// File: rtl/soc_pio_in_edge.sv
// Avalon-MM input PIO: 2-flop synchroniser, armed edge capture, maskable level irq, read latency 1.
// Define SOC_PIO_IN_DEBOUNCE_EN to add a per-bit stability filter of DEBOUNCE_CYCLES clocks.
module soc_pio_in_edge #(
  parameter int          WIDTH           = 2,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] IRQ_MASK_RST    = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_writedata;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("soc_pio_in_edge: WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("soc_pio_in_edge: DEBOUNCE_CYCLES must be >= 1");
  end

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef SOC_PIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The increment that reaches DEBOUNCE_CYCLES is the one that accepts s2.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             f_bit;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        f_bit <= 1'b0;
      end else if (s2[gi] == f_bit) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        f_bit <= s2[gi];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign f[gi] = f_bit;
  end
`else
  assign f = s2;
`endif

  assign armed = (arm_cnt == 2'd3);
  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    ev = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       ev = f & ~prev;
        1:       ev = ~f & prev;
        default: ev = f ^ prev;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = f;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a coincident edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= IRQ_MASK_RST[WIDTH-1:0];
      arm_cnt     <= 2'd0;
      readdata    <= '0;
    end else begin
      prev        <= f;
      edgecapture <= (edgecapture & ~clr) | ev;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      readdata    <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_soc_pio_in_edge.sv
// Scoreboard bench: DUT a (rising edge) and DUT b (any edge) share the bus; probes queue expectations.
module tb_soc_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_a;
  logic [1:0]  in_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dut;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
    string       name;
  } probe_t;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } imm_t;

  probe_t pq[$];
  imm_t   iq[$];
  event   imm_ev;
  logic   rd_issue = 1'b0;
  logic   rd_valid = 1'b0;

  soc_pio_in_edge #(.WIDTH(2), .EDGE_TYPE(0), .IRQ_MASK_RST(32'h0), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  soc_pio_in_edge #(.WIDTH(2), .EDGE_TYPE(2), .IRQ_MASK_RST(32'h0), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endfunction

  always @(posedge clk) rd_valid <= rd_issue;

  // Read monitor: a probe issued before a posedge is presented on readdata at the next negedge.
  always @(negedge clk) begin : mon
    probe_t p;
    if (rd_valid) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=0 entries required=1 entry");
      end else begin
        p = pq.pop_front();
        cmp({p.name, "_rd"}, p.dut ? readdata_b : readdata_a, p.exp_rd);
        if (p.chk_irq) cmp({p.name, "_irq"}, {31'd0, p.dut ? irq_b : irq_a}, {31'd0, p.exp_irq});
      end
    end
  end

  always @(imm_ev) begin : imm_mon
    imm_t e;
    while (iq.size() > 0) begin
      e = iq.pop_front();
      case (e.sig)
        0:       cmp(e.name, {31'd0, irq_a}, e.exp);
        1:       cmp(e.name, {31'd0, irq_b}, e.exp);
        default: cmp(e.name, readdata_b, e.exp);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe(input logic dut, input logic [1:0] addr, input logic [31:0] exp_rd,
                       input logic chk_irq, input logic exp_irq, input string name);
    probe_t p;
    p.dut = dut; p.exp_rd = exp_rd; p.chk_irq = chk_irq; p.exp_irq = exp_irq; p.name = name;
    pq.push_back(p);
    address = addr; chipselect = 1'b1; write_n = 1'b1; rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0; chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic imm(input int sig, input logic [31:0] exp, input string name);
    imm_t e;
    e.sig = sig; e.exp = exp; e.name = name;
    iq.push_back(e);
    -> imm_ev;
  endtask

`ifdef SOC_PIO_IN_DEBOUNCE_EN
  localparam logic [1:0] INIT_A = 2'b00;
`else
  localparam logic [1:0] INIT_A = 2'b11;
`endif

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_a = INIT_A; in_b = 2'b00;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "rst_capture");
    probe(1'b0, 2'd0, {30'd0, INIT_A}, 1'b1, 1'b0, "rst_data");
    probe(1'b0, 2'd2, 32'h0, 1'b0, 1'b0, "rst_mask");
    probe(1'b0, 2'd1, 32'h0, 1'b0, 1'b0, "rst_addr1");

`ifdef SOC_PIO_IN_DEBOUNCE_EN
    // 3-clock glitch is rejected.
    in_a = 2'b01; tick(3); in_a = 2'b00; tick(12);
    probe(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, "db_glitch_data");
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "db_glitch_cap");
    // 6-clock pulse is accepted four clocks after s2 rises.
    in_a = 2'b01; tick(5);
    probe(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, "db_pulse_early");
    in_a = 2'b00;
    probe(1'b0, 2'd0, 32'h1, 1'b0, 1'b0, "db_pulse_accept");
    tick(15);
    probe(1'b0, 2'd3, 32'h1, 1'b1, 1'b0, "db_pulse_cap");
    probe(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, "db_pulse_release");
    wr(2'd2, 32'h1);
    probe(1'b0, 2'd3, 32'h1, 1'b1, 1'b1, "db_irq");
`else
    // Exact edge latency: capture set at k+2, read of it one cycle later.
    wr(2'd2, 32'h1);
    in_a = 2'b10; tick(5);
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "fall_ignored");
    in_a = 2'b11;
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "lat_k0");
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "lat_k1");
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b1, "lat_k2");
    probe(1'b0, 2'd3, 32'h1, 1'b1, 1'b1, "lat_k3");
    probe(1'b0, 2'd0, 32'h3, 1'b1, 1'b1, "data_after_edge");
    wr(2'd3, 32'h1);
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "w1c_bit0");

    // Masked capture still sets; unmasking raises irq.
    in_a = 2'b01; tick(5);
    in_a = 2'b11; tick(5);
    probe(1'b0, 2'd3, 32'h2, 1'b1, 1'b0, "masked_cap");
    wr(2'd2, 32'h2);
    probe(1'b0, 2'd3, 32'h2, 1'b1, 1'b1, "unmask_irq");
    probe(1'b0, 2'd2, 32'h2, 1'b0, 1'b0, "mask_readback");
    wr(2'd3, 32'h2);
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "w1c_bit1");

    // Clear write lands on the same edge that sets bit0.
    in_a = 2'b10; tick(5);
    in_a = 2'b11; tick(2);
    wr(2'd3, 32'h1);
    probe(1'b0, 2'd3, 32'h1, 1'b1, 1'b0, "set_wins");
    wr(2'd2, 32'h1);
    probe(1'b0, 2'd3, 32'h1, 1'b1, 1'b1, "set_wins_irq");
    wr(2'd3, 32'h1);
    probe(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, "set_wins_clear");

    // Any-edge instance, then asynchronous reset mid-sequence.
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(5);
    wr(2'd2, 32'h1);
    in_b = 2'b01; tick(5);
    probe(1'b1, 2'd3, 32'h1, 1'b1, 1'b1, "any_rise");
    wr(2'd3, 32'h1);
    probe(1'b1, 2'd3, 32'h0, 1'b1, 1'b0, "any_clear");
    in_b = 2'b00; tick(5);
    probe(1'b1, 2'd3, 32'h1, 1'b1, 1'b1, "any_fall");
    wr(2'd3, 32'h1);
    in_b = 2'b01; tick(4);
    imm(1, 32'h1, "pre_reset_irq_b");
    #2 reset_n = 1'b0;
    #1;
    imm(1, 32'h0, "async_irq_b");
    imm(0, 32'h0, "async_irq_a");
    imm(2, 32'h0, "async_readdata_b");
    @(negedge clk);
    reset_n = 1'b1;
    tick(10);
    probe(1'b1, 2'd3, 32'h0, 1'b1, 1'b0, "rearm_no_edge");
    probe(1'b1, 2'd0, 32'h1, 1'b0, 1'b0, "rearm_data");
    probe(1'b1, 2'd2, 32'h0, 1'b0, 1'b0, "rearm_mask");
`endif

    tick(3);
    if (pq.size() != 0 || iq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0 entries", pq.size() + iq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
